c499_enc: RTL and testbench

Check-bit generator that sits directly upstream of the c499 32-bit single-error-correcting decoder. It accepts 32-bit data words over a valid/ready handshake and computes the 8 check bits the decoder expects. Each data/check pair is buffered in a 2-entry output queue. An armable single-bit error injector lets the bench exercise the decoder's correction path. Output bits map one-to-one onto the decoder inputs; the decoder enable N137 is tied high downstream.

---
 rtl/c499_enc.sv | 117 +++++++++++
 tb/tb_c499_enc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/c499_enc.sv
`default_nettype none
// ============================================================================
//  Module   : c499_enc
//  Purpose  : Check-bit generator for the c499 SEC decoder, with a 2-entry
//             output queue and an armable single-bit error injector.
//  Revision : 1.0  initial release
// ============================================================================
module c499_enc (
   input  logic        CK,
   input  logic        RST_N,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [31:0] IN_DATA,
   input  logic        INJ_ARM,
   input  logic [5:0]  INJ_POS,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [31:0] OUT_DATA,
   output logic [7:0]  OUT_CHECK,
   output logic        OUT_ERR_INJ,
   output logic [15:0] WORD_CNT
);

   // Each mask selects the 12 data bits whose parity forms one check bit.
   localparam logic [31:0] C_MASK [8] = '{
      32'h00FF_1111, 32'hFF00_2222, 32'h0F0F_4444, 32'hF0F0_8888,
      32'h1111_00FF, 32'h2222_FF00, 32'h4444_0F0F, 32'h8888_F0F0
   };

   logic [1:0]  r_count;
   logic        r_head;
   logic [31:0] r_data [2];
   logic [7:0]  r_chk  [2];
   logic [1:0]  r_err;
   logic        r_armed;
   logic [5:0]  r_pos;
   logic [15:0] r_word_cnt;

   logic        w_push;
   logic        w_pop;
   logic        w_tail;
   logic        w_eff_arm;
   logic [5:0]  w_eff_pos;
   logic [7:0]  w_raw_chk;
   logic [31:0] w_data_flip;
   logic [7:0]  w_chk_flip;
   logic        w_err;

   for (genvar i = 0; i < 8; i++) begin : g_chk
      assign w_raw_chk[i] = ^(IN_DATA & C_MASK[i]);
   end

   assign IN_READY  = (r_count != 2'd2);
   assign OUT_VALID = (r_count != 2'd0);
   assign w_push    = IN_VALID & IN_READY;
   assign w_pop     = OUT_VALID & OUT_READY;
   assign w_tail    = r_head ^ (r_count == 2'd1);
   assign w_eff_arm = r_armed | INJ_ARM;
   assign w_eff_pos = INJ_ARM ? INJ_POS : r_pos;

   always_comb begin
      w_data_flip = '0;
      w_chk_flip  = '0;
      w_err       = 1'b0;
      if (w_eff_arm) begin
         if (!w_eff_pos[5]) begin
            w_data_flip[w_eff_pos[4:0]] = 1'b1;
            w_err                       = 1'b1;
         end else if (w_eff_pos[4:3] == 2'b00) begin
            w_chk_flip[w_eff_pos[2:0]] = 1'b1;
            w_err                      = 1'b1;
         end
      end
   end

   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) begin
         r_count    <= 2'd0;
         r_head     <= 1'b0;
         r_err      <= 2'b00;
         r_armed    <= 1'b0;
         r_pos      <= 6'd0;
         r_word_cnt <= 16'd0;
         for (int k = 0; k < 2; k++) begin
            r_data[k] <= 32'd0;
            r_chk[k]  <= 8'd0;
         end
      end else begin
         if (w_push) begin
            r_data[w_tail] <= IN_DATA ^ w_data_flip;
            r_chk[w_tail]  <= w_raw_chk ^ w_chk_flip;
            r_err[w_tail]  <= w_err;
            r_word_cnt     <= r_word_cnt + 16'd1;
         end
         if (w_pop)
            r_head <= ~r_head;
         if (w_push && !w_pop)
            r_count <= r_count + 2'd1;
         else if (w_pop && !w_push)
            r_count <= r_count - 2'd1;
         // An accept consumes any arm, including one raised in the same cycle.
         if (w_push)
            r_armed <= 1'b0;
         else if (INJ_ARM)
            r_armed <= 1'b1;
         if (INJ_ARM)
            r_pos <= INJ_POS;
      end
   end

   assign OUT_DATA    = r_data[r_head];
   assign OUT_CHECK   = r_chk[r_head];
   assign OUT_ERR_INJ = r_err[r_head];
   assign WORD_CNT    = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_c499_enc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_c499_enc
//  Purpose  : Directed self-checking bench for c499_enc.
//  Revision : 1.0  initial release
// ============================================================================
module tb_c499_enc;

   logic        CK = 1'b0;
   logic        RST_N = 1'b0;
   logic        IN_VALID = 1'b0;
   logic        IN_READY;
   logic [31:0] IN_DATA = '0;
   logic        INJ_ARM = 1'b0;
   logic [5:0]  INJ_POS = '0;
   logic        OUT_VALID;
   logic        OUT_READY = 1'b0;
   logic [31:0] OUT_DATA;
   logic [7:0]  OUT_CHECK;
   logic        OUT_ERR_INJ;
   logic [15:0] WORD_CNT;

   int n_assert = 0;
   int n_fail   = 0;

   c499_enc dut (
      .CK(CK), .RST_N(RST_N),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
      .INJ_ARM(INJ_ARM), .INJ_POS(INJ_POS),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .OUT_DATA(OUT_DATA), .OUT_CHECK(OUT_CHECK),
      .OUT_ERR_INJ(OUT_ERR_INJ), .WORD_CNT(WORD_CNT)
   );

   always #5 CK = ~CK;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  chk;
   } vec_t;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Decoder column of data bit k, built from the group structure of the equations.
   function automatic logic [7:0] col(input int k);
      logic [7:0] c;
      int j;
      c = '0;
      j = k % 4;
      if (k < 16) begin
         c[j] = 1'b1;
         c[(k < 8) ? 4 : 5] = 1'b1;
         c[(((k / 4) % 2) == 0) ? 6 : 7] = 1'b1;
      end else begin
         c[(k < 24) ? 0 : 1] = 1'b1;
         c[(((k / 4) % 2) == 0) ? 2 : 3] = 1'b1;
         c[4 + j] = 1'b1;
      end
      return c;
   endfunction

   function automatic logic [7:0] model_chk(input logic [31:0] d);
      logic [7:0] c;
      c = '0;
      for (int k = 0; k < 32; k++)
         if (d[k]) c ^= col(k);
      return c;
   endfunction

   function automatic logic [31:0] decode(input logic [31:0] d, input logic [7:0] c);
      logic [7:0]  syn;
      logic [31:0] fix;
      syn = c ^ model_chk(d);
      fix = d;
      for (int k = 0; k < 32; k++)
         if (syn != 8'd0 && syn == col(k)) fix[k] = ~fix[k];
      return fix;
   endfunction

   // Called just after a negedge with an empty queue: one accept, sample, one pop.
   task automatic send(input logic [31:0] d, input logic arm, input logic [5:0] pos,
                       output logic v, output logic [31:0] od, output logic [7:0] oc,
                       output logic oe);
      IN_VALID = 1'b1; IN_DATA = d; INJ_ARM = arm; INJ_POS = pos;
      @(negedge CK);
      IN_VALID = 1'b0; INJ_ARM = 1'b0;
      v = OUT_VALID; od = OUT_DATA; oc = OUT_CHECK; oe = OUT_ERR_INJ;
      OUT_READY = 1'b1;
      @(negedge CK);
      OUT_READY = 1'b0;
   endtask

   task automatic send_check(input string nm, input logic [31:0] d, input logic arm,
                             input logic [5:0] pos, input logic [31:0] ed,
                             input logic [7:0] ec, input logic ee);
      logic v, oe;
      logic [31:0] od;
      logic [7:0]  oc;
      send(d, arm, pos, v, od, oc, oe);
      check({nm, " valid"}, 64'(v), 64'(1));
      check({nm, " data"},  64'(od), 64'(ed));
      check({nm, " check"}, 64'(oc), 64'(ec));
      check({nm, " errinj"}, 64'(oe), 64'(ee));
   endtask

   initial begin
      vec_t vecs [8];
      logic [31:0] got [$];
      logic [31:0] bp_exp [3];
      logic v, oe;
      logic [31:0] od, d;
      logic [7:0]  oc;

      vecs[0] = '{32'h0000_0001, 8'h51};
      vecs[1] = '{32'h0001_0000, 8'h15};
      vecs[2] = '{32'h8000_0000, 8'h8A};
      vecs[3] = '{32'hFFFF_FFFF, 8'h00};
      vecs[4] = '{32'h0000_FFFF, 8'h00};
      vecs[5] = '{32'h0000_0003, 8'h03};
      vecs[6] = '{32'h0000_0100, 8'h61};
      vecs[7] = '{32'h0010_0000, 8'h19};

      // Reset state
      @(negedge CK);
      check("rst out_valid", 64'(OUT_VALID), 64'(0));
      check("rst in_ready",  64'(IN_READY),  64'(1));
      check("rst out_data",  64'(OUT_DATA),  64'(0));
      check("rst out_check", 64'(OUT_CHECK), 64'(0));
      check("rst err_inj",   64'(OUT_ERR_INJ), 64'(0));
      check("rst word_cnt",  64'(WORD_CNT),  64'(0));
      RST_N = 1'b1;
      @(negedge CK);

      for (int i = 0; i < 8; i++)
         send_check($sformatf("enc%0d", i), vecs[i].data, 1'b0, 6'd0,
                    vecs[i].data, vecs[i].chk, 1'b0);
      check("empty after pops", 64'(OUT_VALID), 64'(0));
      check("word_cnt after enc", 64'(WORD_CNT), 64'(8));

      // Backpressure: A, B fill the queue, C held until space frees up
      bp_exp = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
      IN_VALID = 1'b1; IN_DATA = bp_exp[0];
      @(negedge CK);
      IN_DATA = bp_exp[1];
      @(negedge CK);
      check("bp full in_ready", 64'(IN_READY), 64'(0));
      check("bp head A", 64'(OUT_DATA), 64'(bp_exp[0]));
      IN_DATA = bp_exp[2];
      @(negedge CK);
      check("bp still full", 64'(IN_READY), 64'(0));
      check("bp head stable", 64'(OUT_DATA), 64'(bp_exp[0]));
      OUT_READY = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic acc;
         acc = IN_VALID && IN_READY;
         if (OUT_VALID && OUT_READY) got.push_back(OUT_DATA);
         @(negedge CK);
         if (acc) IN_VALID = 1'b0;
      end
      OUT_READY = 1'b0;
      check("bp count out", 64'(got.size()), 64'(3));
      for (int i = 0; i < got.size() && i < 3; i++)
         check($sformatf("bp order %0d", i), 64'(got[i]), 64'(bp_exp[i]));

      // Injection
      INJ_ARM = 1'b1; INJ_POS = 6'd5;
      @(negedge CK);
      INJ_ARM = 1'b0;
      send_check("inj pos5", 32'h0, 1'b0, 6'd0, 32'h0000_0020, 8'h00, 1'b1);
      send_check("inj pos5 next clean", 32'h0, 1'b0, 6'd0, 32'h0, 8'h00, 1'b0);
      INJ_ARM = 1'b1; INJ_POS = 6'd35;
      @(negedge CK);
      INJ_ARM = 1'b0;
      send_check("inj pos35", 32'h0, 1'b0, 6'd0, 32'h0, 8'h08, 1'b1);
      INJ_ARM = 1'b1; INJ_POS = 6'd50;
      @(negedge CK);
      INJ_ARM = 1'b0;
      send_check("inj pos50", 32'h0, 1'b0, 6'd0, 32'h0, 8'h00, 1'b0);
      send_check("inj same cycle pos0", 32'h0, 1'b1, 6'd0, 32'h0000_0001, 8'h00, 1'b1);
      send_check("inj after same cycle", 32'h0, 1'b0, 6'd0, 32'h0, 8'h00, 1'b0);

      // Reset mid-stream with full queue and a pending arm
      IN_VALID = 1'b1; IN_DATA = 32'h1;
      @(negedge CK);
      IN_DATA = 32'h2;
      @(negedge CK);
      IN_VALID = 1'b0; INJ_ARM = 1'b1; INJ_POS = 6'd3;
      @(negedge CK);
      INJ_ARM = 1'b0;
      check("mid full", 64'(IN_READY), 64'(0));
      #2 RST_N = 1'b0;
      #1;
      check("mid rst out_valid", 64'(OUT_VALID), 64'(0));
      check("mid rst in_ready",  64'(IN_READY),  64'(1));
      check("mid rst word_cnt",  64'(WORD_CNT),  64'(0));
      check("mid rst out_data",  64'(OUT_DATA),  64'(0));
      @(negedge CK);
      RST_N = 1'b1;
      @(negedge CK);
      send_check("post rst clean", 32'h0, 1'b0, 6'd0, 32'h0, 8'h00, 1'b0);

      // Counter wrap from a fresh reset
      RST_N = 1'b0;
      @(negedge CK);
      RST_N = 1'b1;
      @(negedge CK);
      IN_VALID = 1'b1; IN_DATA = 32'h0; OUT_READY = 1'b1;
      repeat (65536) @(negedge CK);
      IN_VALID = 1'b0;
      check("wrap 65536", 64'(WORD_CNT), 64'(0));
      IN_VALID = 1'b1;
      @(negedge CK);
      IN_VALID = 1'b0;
      check("wrap 65537", 64'(WORD_CNT), 64'(1));
      repeat (2) @(negedge CK);
      OUT_READY = 1'b0;
      check("wrap drained", 64'(OUT_VALID), 64'(0));

      // End-to-end through a reference single-error corrector
      for (int p = 0; p < 32; p++) begin
         d = $urandom;
         send(d, 1'b1, 6'(p), v, od, oc, oe);
         check($sformatf("e2e flip %0d", p), 64'(od), 64'(d ^ (32'h1 << p)));
         check($sformatf("e2e decode %0d", p), 64'(decode(od, oc)), 64'(d));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
